// File: rtl/exec_unit.sv
// Execute stage between register-file read ports and its write port.
// Single-cycle ALU ops plus 32-iteration shift-add multiply and restoring divide.
module exec_unit #(
    parameter int WIDTH     = 32,
    parameter int AW        = 4,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [AW-1:0]    rd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             wen,
    output logic [AW-1:0]    waddr,
    output logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;
    localparam logic [3:0] OP_MOVB = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wen_q, wen_d;
    logic             err_q, err_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    // opa: multiplicand / dividend-then-quotient; opb: multiplier / divisor;
    // acc: product accumulator / partial remainder.
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic             rem_sel_q, rem_sel_d;

    logic             accept;
    logic             is_muldiv;
    logic             is_illegal;
    logic             last_iter;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;

    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_quo_next;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));
    assign shamt     = b[SHW-1:0];

    assign is_muldiv  = MULDIV_EN && (op == OP_MUL || op == OP_DIVU || op == OP_REMU);
    assign is_illegal = (op > OP_MOVB) ||
                        (!MULDIV_EN && (op == OP_MUL || op == OP_DIVU || op == OP_REMU));

    always_comb begin
        alu_res = '0;
        unique case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_MOVB: alu_res = b;
            default: alu_res = '0;
        endcase
    end

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
    // With a zero divisor every step "fits", yielding all-ones quotient and remainder == a.
    assign mul_acc_next = acc_q + (opb_q[0] ? opa_q : '0);
    assign div_diff     = {acc_q, opa_q[WIDTH-1]} - {1'b0, opb_q};
    assign div_ok       = ~div_diff[WIDTH];
    assign div_rem_next = div_ok ? div_diff[WIDTH-1:0] : {acc_q[WIDTH-2:0], opa_q[WIDTH-1]};
    assign div_quo_next = {opa_q[WIDTH-2:0], div_ok};

    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wen_d     = 1'b0;
        err_d     = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        rd_d      = rd_q;
        rem_sel_d = rem_sel_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_illegal) begin
                        err_d = 1'b1;
                    end else if (is_muldiv) begin
                        opa_d     = a;
                        opb_d     = b;
                        acc_d     = '0;
                        cnt_d     = '0;
                        rd_d      = rd;
                        rem_sel_d = (op == OP_REMU);
                        state_d   = (op == OP_MUL) ? S_MUL : S_DIV;
                    end else begin
                        wen_d   = 1'b1;
                        waddr_d = rd;
                        wdata_d = alu_res;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_acc_next;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    wen_d   = 1'b1;
                    waddr_d = rd_q;
                    wdata_d = mul_acc_next;
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                acc_d = div_rem_next;
                opa_d = div_quo_next;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    wen_d   = 1'b1;
                    waddr_d = rd_q;
                    wdata_d = rem_sel_q ? div_rem_next : div_quo_next;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // NOTE: iteration datapath is left unreset; it is always loaded on accept before use.
    always_ff @(posedge clk) begin
        opa_q     <= opa_d;
        opb_q     <= opb_d;
        acc_q     <= acc_d;
        rd_q      <= rd_d;
        rem_sel_q <= rem_sel_d;
    end

    assign wen   = wen_q;
    assign err   = err_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: vector table for single-cycle ops,
// hand-written sequences for multiply/divide, abort on reset and MULDIV_EN=0.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic        wen;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        err;

    logic        nv_valid;
    logic        nv_ready;
    logic        nv_wen;
    logic [3:0]  nv_waddr;
    logic [31:0] nv_wdata;
    logic        nv_busy;
    logic        nv_err;

    always #5 clk = ~clk;

    exec_unit #(.WIDTH(32), .AW(4), .MULDIV_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .a(a), .b(b),
        .wen(wen), .waddr(waddr), .wdata(wdata), .busy(busy), .err(err)
    );

    exec_unit #(.WIDTH(32), .AW(4), .MULDIV_EN(1'b0)) u_nomd (
        .clk(clk), .rst(rst), .in_valid(nv_valid), .in_ready(nv_ready),
        .op(op), .rd(rd), .a(a), .b(b),
        .wen(nv_wen), .waddr(nv_waddr), .wdata(nv_wdata), .busy(nv_busy), .err(nv_err)
    );

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    typedef struct {
        logic        wen;
        logic        err;
        logic [3:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[15];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [3:0]  last_addr;
    logic [31:0] last_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] d, input logic [31:0] res, input logic ill);
        exp_t e;
        if (ill) begin
            e = '{wen: 1'b0, err: 1'b1, waddr: last_addr, wdata: last_data};
        end else begin
            e = '{wen: 1'b1, err: 1'b0, waddr: d, wdata: res};
            last_addr = d;
            last_data = res;
        end
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty when output expected", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".wen"},   wen,   e.wen);
            check({tag, ".err"},   err,   e.err);
            check({tag, ".waddr"}, waddr, e.waddr);
            check({tag, ".wdata"}, wdata, e.wdata);
        end
    endtask

    // Accept one multi-cycle op, scramble inputs while busy, check timing and result.
    task automatic run_mc(input string tag, input logic [3:0] o, input logic [3:0] d,
                          input logic [31:0] x, input logic [31:0] y, input logic [31:0] res);
        int bad_busy;
        bad_busy = 0;
        in_valid = 1'b1;
        op = o; rd = d; a = x; b = y;
        push_exp(d, res, 1'b0);
        step();
        a  = $urandom;
        b  = $urandom;
        rd = ~d;
        for (int k = 1; k <= 31; k++) begin
            step();
            if (busy !== 1'b1 || in_ready !== 1'b0 || wen !== 1'b0) bad_busy++;
        end
        check({tag, ".busy_window"}, bad_busy, 0);
        step();
        in_valid = 1'b0;
        check_out(tag);
        check({tag, ".ready_at_wen"}, in_ready, 1'b1);
        check({tag, ".busy_at_wen"},  busy,     1'b0);
        step();
        check({tag, ".no_second"}, {wen, busy}, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;

        vecs = '{
            '{4'd0,  4'd3,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0},
            '{4'd1,  4'd4,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0},
            '{4'd2,  4'd5,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0},
            '{4'd3,  4'd6,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0},
            '{4'd4,  4'd7,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0},
            '{4'd14, 4'd9,  32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b1},
            '{4'd5,  4'd8,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0},
            '{4'd6,  4'd9,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0},
            '{4'd7,  4'd10, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0},
            '{4'd8,  4'd11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0},
            '{4'd9,  4'd12, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
            '{4'd15, 4'd2,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1},
            '{4'd13, 4'd0,  32'h0000_0123, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0},
            '{4'd0,  4'd15, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
            '{4'd1,  4'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0}
        };

        rst = 1'b1; in_valid = 1'b0; nv_valid = 1'b0;
        op = '0; rd = '0; a = '0; b = '0;
        last_addr = '0; last_data = '0;
        step();
        step();
        rst = 1'b0;
        check("reset.wen",      wen,      1'b0);
        check("reset.err",      err,      1'b0);
        check("reset.busy",     busy,     1'b0);
        check("reset.in_ready", in_ready, 1'b1);
        check("reset.waddr",    waddr,    4'd0);
        check("reset.wdata",    wdata,    32'd0);

        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            op = vecs[i].op; rd = vecs[i].rd; a = vecs[i].a; b = vecs[i].b;
            push_exp(vecs[i].rd, vecs[i].res, vecs[i].ill);
            step();
            check_out($sformatf("vec%0d", i));
            check($sformatf("vec%0d.ready", i), in_ready, 1'b1);
        end
        in_valid = 1'b0;
        step();
        check("idle.wen", wen, 1'b0);
        check("idle.err", err, 1'b0);
        check("idle.hold_data", wdata, last_data);

        run_mc("mul_basic", 4'd10, 4'd7,  32'h0001_0001, 32'h0001_0001, 32'h0002_0001);
        run_mc("mul_max",   4'd10, 4'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_mc("divu",      4'd11, 4'd3,  32'd100,       32'd7,         32'd14);
        run_mc("remu",      4'd12, 4'd4,  32'd100,       32'd7,         32'd2);
        run_mc("divu_z",    4'd11, 4'd5,  32'd5,         32'd0,         32'hFFFF_FFFF);
        run_mc("remu_z",    4'd12, 4'd6,  32'd5,         32'd0,         32'd5);
        run_mc("divu_big",  4'd11, 4'd8,  32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF);

        // Abort a divide mid-flight with reset.
        in_valid = 1'b1;
        op = 4'd11; rd = 4'd9; a = 32'd1000; b = 32'd3;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_addr = '0; last_data = '0;
        check("abort.busy",     busy,     1'b0);
        check("abort.in_ready", in_ready, 1'b1);
        check("abort.wen",      wen,      1'b0);
        check("abort.wdata",    wdata,    32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (wen !== 1'b0 || busy !== 1'b0) seen++;
        end
        check("abort.quiet", seen, 0);
        in_valid = 1'b1;
        op = 4'd0; rd = 4'd1; a = 32'd2; b = 32'd3;
        push_exp(4'd1, 32'd5, 1'b0);
        step();
        in_valid = 1'b0;
        check_out("post_abort_add");

        // MULDIV_EN=0: multiply/divide opcodes are illegal.
        for (int o = 10; o <= 12; o++) begin
            nv_valid = 1'b1;
            op = 4'(o); rd = 4'd5; a = 32'd3; b = 32'd4;
            step();
            nv_valid = 1'b0;
            check($sformatf("nomd%0d.err", o),   nv_err,   1'b1);
            check($sformatf("nomd%0d.wen", o),   nv_wen,   1'b0);
            check($sformatf("nomd%0d.busy", o),  nv_busy,  1'b0);
            check($sformatf("nomd%0d.ready", o), nv_ready, 1'b1);
            step();
            check($sformatf("nomd%0d.err_pulse", o), nv_err,  1'b0);
            check($sformatf("nomd%0d.busy2", o),     nv_busy, 1'b0);
        end
        check("nomd.waddr", nv_waddr, 4'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage directly downstream of the 16x32 register file's read ports and upstream of its write port.
- Consumes operand pair a/b (the file's data1/data2) plus opcode and destination index.
- Produces a registered write-back (wen/waddr/wdata) that drives the register file's single write port.
- Single-cycle ALU ops; iterative shift-add multiply and restoring divide take 32 iterations under a small FSM with a valid/ready handshake toward decode.

Parameters:
- WIDTH, 32, operand/result width.
- AW, 4, register index width (16 registers).
- MULDIV_EN, 1, 1 = MUL/DIVU/REMU implemented; 0 = those opcodes treated as illegal.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  decode presents an operation this cycle.
- in_ready  output  1  unit can accept; transfer occurs on a posedge with in_valid & in_ready.
- op  input  4  opcode, encoding below.
- rd  input  AW  destination register index.
- a  input  WIDTH  operand 1 (register file data1).
- b  input  WIDTH  operand 2 (register file data2).
- wen  output  1  one-cycle write-back strobe to the register file.
- waddr  output  AW  write-back destination.
- wdata  output  WIDTH  write-back value.
- busy  output  1  multi-cycle operation in progress.
- err  output  1  one-cycle pulse on acceptance of an illegal opcode.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount is b[4:0].
  - 8 SLT (signed, result 0/1), 9 SLTU (unsigned, result 0/1).
  - 10 MUL (low WIDTH bits of the unsigned product), 11 DIVU, 12 REMU.
  - 13 MOVB (result = b).
  - 14, 15 illegal.
- Arithmetic: all results modulo 2^WIDTH; no flags.
  - DIVU with b=0 returns all-ones.
  - REMU with b=0 returns a.
- FSM states: IDLE, MUL, DIV.
  - IDLE: in_ready=1, busy=0.
  - Accept of a single-cycle op: stay in IDLE. Next cycle wen=1, waddr=rd, wdata=result. Latency 1; back-to-back accepts every cycle are allowed.
  - Accept of MUL: load multiplicand, multiplier, acc=0, cnt=0; go to MUL.
  - Accept of DIVU/REMU: load dividend, divisor, rem=0, cnt=0, plus a quotient/remainder select; go to DIV.
  - MUL/DIV: in_ready=0, busy=1. One iteration per posedge, cnt increments.
  - Iteration 32 (cnt==31): registers wen=1 with the final result and returns to IDLE. wen is visible 32 cycles after the accept edge; in_ready=1 in that same cycle.
- wen is high for exactly one cycle per accepted legal op; it is never asserted for illegal ops.
- Illegal op (14/15, or 10–12 when MULDIV_EN=0): accepted (in_ready stays 1), err=1 next cycle, wen=0, state stays IDLE.
- waddr/wdata hold their last values when wen=0.
- Inputs are sampled only at the accept edge; changes to a/b/rd/op during MUL/DIV are ignored.
- in_valid while in_ready=0: no transfer. Decode must hold the op.
- Reset (rst=1 at a posedge): state=IDLE, wen=0, err=0, busy=0, waddr=0, wdata=0, cnt=0. A multi-cycle op in flight is aborted with no write-back. in_ready=1 from the first cycle after reset.
- rd=0 is written like any other register; there is no hardwired zero.
- Reset has priority over acceptance in the same cycle.

Test Plan:
- ADD a=0x7FFFFFFF b=0x00000001 rd=3 -> next cycle wen=1, waddr=3, wdata=0x80000000. Then SUB a=0 b=1 rd=4 back-to-back -> wdata=0xFFFFFFFF on the following cycle.
- SRA a=0x80000000 b=0x0000001F -> 0xFFFFFFFF. SLT a=0xFFFFFFFF b=1 -> 1. SLTU with the same operands -> 0.
- MUL a=0x00010001 b=0x00010001 rd=7 -> busy=1 and in_ready=0 for cycles 1–31. wen=1, wdata=0x00020001 exactly 32 cycles after accept. in_valid held during busy causes no second accept.
- DIVU a=100 b=7 -> wdata=14. REMU a=100 b=7 -> 2. DIVU a=5 b=0 -> 0xFFFFFFFF. REMU a=5 b=0 -> 5.
- op=14 accepted -> err=1 for one cycle, wen=0. With MULDIV_EN=0, op=10 -> err=1, wen=0, busy never asserted.
- Start DIVU, assert rst at iteration 10 -> no wen, busy=0, in_ready=1 next cycle. A subsequent ADD 2+3 rd=1 -> wdata=5.
